// File: rtl/aes_pkg.sv
// Shared types and constants for the AES byte-to-block packer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: block geometry, PKCS#7 full-pad byte, packer state enum and a
// lane-write helper. Lane 0 is the first byte of a block and sits in [127:120].
package aes_pkg;

  localparam int         AES_BLK_BITS  = 128;
  localparam int         AES_BLK_BYTES = 16;
  localparam logic [7:0] PKCS7_FULL    = 8'h10;

  typedef logic [AES_BLK_BITS-1:0] blk_t;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    XPAD = 1'b1
  } pk_state_t;

  // Replace byte lane idx (0 = most significant byte) of b with v.
  function automatic blk_t set_lane(input blk_t b, input logic [3:0] idx, input logic [7:0] v);
    blk_t r;
    r = b;
    r[(AES_BLK_BYTES - 1 - int'(idx)) * 8 +: 8] = v;
    return r;
  endfunction

endpackage

// File: rtl/aes_pkcs7_pad.sv
// Fills the unused tail of a partial block with PKCS#7 pad bytes or zeros.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   acc    in  128  block whose lanes 0..k-1 hold message bytes
//   k      in  5    number of message bytes in the block (1..16)
//   pad_en in  1    1 = lanes k..15 get 8'(16-k); 0 = lanes k..15 get zero
//   padded out 128  acc with lanes k..15 overwritten; k==16 passes acc through
module aes_pkcs7_pad
  import aes_pkg::*;
(
  input  logic [AES_BLK_BITS-1:0] acc,
  input  logic [4:0]              k,
  input  logic                    pad_en,
  output logic [AES_BLK_BITS-1:0] padded
);

  logic [7:0] pad_byte;

  always_comb begin
    // 16-k is 0..15 for legal k, so it fits the low five bits.
    pad_byte = pad_en ? {3'b000, 5'd16 - k} : 8'h00;
    padded   = acc;
    for (int i = 0; i < AES_BLK_BYTES; i++) begin
      if (5'(i) >= k) begin
        padded[(AES_BLK_BYTES - 1 - i) * 8 +: 8] = pad_byte;
      end
    end
  end

endmodule

// File: rtl/aes_block_packer.sv
// Packs a byte stream into 128-bit AES plaintext blocks, optional PKCS#7 tail.
// Latency: block valid one cycle after its completing byte is accepted.
// Backpressure: in_ready drops while the output register is held; no byte lost.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_data/valid/last  byte input; in_last marks the final message byte
//   in_ready            byte accepted when in_valid && in_ready
//   blk_data/valid/last block output, first byte in [127:120]
//   blk_ready           downstream takes the block when blk_valid && blk_ready
//   blk_cnt             number of completed block handshakes (wraps)
module aes_block_packer
  import aes_pkg::*;
#(
  parameter bit PAD_EN = 1'b1,
  parameter int CNT_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              in_data,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic [AES_BLK_BITS-1:0] blk_data,
  output logic                    blk_valid,
  output logic                    blk_last,
  input  logic                    blk_ready,
  output logic [CNT_W-1:0]        blk_cnt
);

  pk_state_t state, state_nxt;

  logic [AES_BLK_BITS-1:0] acc;
  logic [3:0]              cnt;

  logic                    out_free;
  logic                    accept;
  logic                    complete;
  logic [4:0]              k;
  logic [AES_BLK_BITS-1:0] acc_wr;
  logic [AES_BLK_BITS-1:0] padded;

  logic                    load;
  logic [AES_BLK_BITS-1:0] load_dat;
  logic                    load_last;

  // The output register can take a new block when empty or being drained
  // this cycle, which is what lets back-to-back blocks run without a bubble.
  assign out_free = !blk_valid || blk_ready;
  // rst_n gating keeps in_ready low for the whole reset pulse, not just
  // after the registers settle.
  assign in_ready = rst_n && (state == FILL) && out_free;
  assign accept   = in_valid && in_ready;
  assign k        = {1'b0, cnt} + 5'd1;
  // Block content including the byte being accepted this cycle.
  assign acc_wr   = set_lane(acc, cnt, in_data);
  assign complete = accept && (in_last || (cnt == 4'd15));

  aes_pkcs7_pad u_pad (
    .acc    (acc_wr),
    .k      (k),
    .pad_en (PAD_EN),
    .padded (padded)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    load_dat  = acc_wr;
    load_last = 1'b0;
    case (state)
      FILL: begin
        if (accept && in_last) begin
          load     = 1'b1;
          load_dat = padded;
          if (PAD_EN && (k == 5'd16)) begin
            // A full final block still needs a whole block of 0x10 after it.
            load_last = 1'b0;
            state_nxt = XPAD;
          end else begin
            load_last = 1'b1;
          end
        end else if (accept && (cnt == 4'd15)) begin
          load      = 1'b1;
          load_dat  = acc_wr;
          load_last = 1'b0;
        end
      end
      XPAD: begin
        if (out_free) begin
          load      = 1'b1;
          load_dat  = {AES_BLK_BYTES{PKCS7_FULL}};
          load_last = 1'b1;
          state_nxt = FILL;
        end
      end
      default: begin
        state_nxt = FILL;
      end
    endcase
  end

  // Stale lanes from an earlier block need no clearing: every lane is either
  // rewritten by a new byte or overwritten by padding before it is emitted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= 4'd0;
    end else if (accept) begin
      acc <= acc_wr;
      cnt <= complete ? 4'd0 : cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_data  <= '0;
      blk_valid <= 1'b0;
      blk_last  <= 1'b0;
    end else if (load) begin
      blk_data  <= load_dat;
      blk_valid <= 1'b1;
      blk_last  <= load_last;
    end else if (blk_ready) begin
      blk_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_cnt <= '0;
    end else if (blk_valid && blk_ready) begin
      blk_cnt <= blk_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_aes_block_packer.sv
// Directed bench for aes_block_packer: one PAD_EN=1 instance and one
// PAD_EN=0 instance with a 2-bit block counter share the same stimulus.
// Expected blocks are written out by hand.
module tb_aes_block_packer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_last;
  logic         blk_ready;

  logic         in_ready,  in_ready0;
  logic [127:0] blk_data,  blk_data0;
  logic         blk_valid, blk_valid0;
  logic         blk_last,  blk_last0;
  logic [31:0]  blk_cnt;
  logic [1:0]   blk_cnt0;

  int total = 0;
  int bad   = 0;

  logic [127:0] q[$];
  logic         ql[$];
  logic [127:0] q0[$];
  logic         ql0[$];

  always #5 clk = ~clk;

  aes_block_packer #(.PAD_EN(1'b1), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .blk_data(blk_data), .blk_valid(blk_valid), .blk_last(blk_last),
    .blk_ready(blk_ready), .blk_cnt(blk_cnt)
  );

  aes_block_packer #(.PAD_EN(1'b0), .CNT_W(2)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready0),
    .blk_data(blk_data0), .blk_valid(blk_valid0), .blk_last(blk_last0),
    .blk_ready(blk_ready), .blk_cnt(blk_cnt0)
  );

  // Record every completed output handshake of both instances.
  always @(posedge clk) begin
    if (blk_valid && blk_ready) begin
      q.push_back(blk_data);
      ql.push_back(blk_last);
    end
    if (blk_valid0 && blk_ready) begin
      q0.push_back(blk_data0);
      ql0.push_back(blk_last0);
    end
  end

  function automatic logic [127:0] qget(input int i);
    if (i < q.size()) return q[i];
    return 'x;
  endfunction

  function automatic logic qlget(input int i);
    if (i < ql.size()) return ql[i];
    return 1'bx;
  endfunction

  function automatic logic [127:0] q0get(input int i);
    if (i < q0.size()) return q0[i];
    return 'x;
  endfunction

  function automatic logic ql0get(input int i);
    if (i < ql0.size()) return ql0[i];
    return 1'bx;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    idle(2);
    rst_n = 1'b1;
    q.delete(); ql.delete(); q0.delete(); ql0.delete();
  endtask

  // Present one byte from a negedge, hold it until accepted, and return at
  // the negedge after the accepting edge with in_valid dropped.
  task automatic send(input logic [7:0] d, input logic last);
    int n;
    n = 0;
    in_data  = d;
    in_valid = 1'b1;
    in_last  = last;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $error("FAIL send_timeout observed=not_accepted expected=accepted byte=%h", d);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    blk_ready = 1'b1;

    // Reset state.
    #12;
    chk("rst_in_ready",  128'(in_ready),  128'd0);
    chk("rst_blk_valid", 128'(blk_valid), 128'd0);
    chk("rst_blk_last",  128'(blk_last),  128'd0);
    chk("rst_blk_data",  blk_data,        128'd0);
    chk("rst_blk_cnt",   128'(blk_cnt),   128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 128'(in_ready), 128'd1);

    // 1: sixteen bytes, last on the 16th -> full block then an all-0x10 block.
    do_reset();
    for (int i = 0; i < 16; i++) send(8'(i), i == 15);
    chk("t1_lat_valid", 128'(blk_valid), 128'd1);
    chk("t1_lat_data",  blk_data, 128'h000102030405060708090A0B0C0D0E0F);
    chk("t1_lat_last",  128'(blk_last), 128'd0);
    chk("t1_xpad_in_ready", 128'(in_ready), 128'd0);
    chk("t1_nopad_last", 128'(blk_last0), 128'd1);
    idle(4);
    chk("t1_nblk",  128'(q.size()), 128'd2);
    chk("t1_blk0",  qget(0), 128'h000102030405060708090A0B0C0D0E0F);
    chk("t1_last0", 128'(qlget(0)), 128'd0);
    chk("t1_blk1",  qget(1), {16{8'h10}});
    chk("t1_last1", 128'(qlget(1)), 128'd1);
    chk("t1_cnt",   128'(blk_cnt), 128'd2);
    chk("t1_nopad_nblk", 128'(q0.size()), 128'd1);

    // 2/3: three bytes with last, PKCS#7 and zero-fill instances.
    do_reset();
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    send(8'hCC, 1'b1);
    chk("t2_lat_valid", 128'(blk_valid), 128'd1);
    chk("t2_data", blk_data, {8'hAA, 8'hBB, 8'hCC, {13{8'h0D}}});
    chk("t2_last", 128'(blk_last), 128'd1);
    chk("t3_lat_valid", 128'(blk_valid0), 128'd1);
    chk("t3_data", blk_data0, {8'hAA, 8'hBB, 8'hCC, {13{8'h00}}});
    chk("t3_last", 128'(blk_last0), 128'd1);
    idle(4);
    chk("t2_nblk", 128'(q.size()), 128'd1);
    chk("t3_nblk", 128'(q0.size()), 128'd1);
    chk("t3_blk0", q0get(0), {8'hAA, 8'hBB, 8'hCC, {13{8'h00}}});
    chk("t3_last0", 128'(ql0get(0)), 128'd1);
    chk("t2_valid_clear", 128'(blk_valid), 128'd0);

    // 4: 32 bytes with a 10-cycle stall after the first block appears.
    do_reset();
    blk_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 32; i++) send(8'(i), 1'b0);
      end
      begin
        int w;
        w = 0;
        while (!blk_valid && w < 200) begin
          @(negedge clk);
          w++;
        end
        if (w >= 200) begin
          total++;
          bad++;
          $error("FAIL t4_wait_valid observed=no_block expected=block");
        end
        for (int c = 0; c < 10; c++) begin
          chk("t4_stall_in_ready", 128'(in_ready), 128'd0);
          chk("t4_stall_data", blk_data, 128'h000102030405060708090A0B0C0D0E0F);
          @(negedge clk);
        end
        blk_ready = 1'b1;
      end
    join
    idle(4);
    chk("t4_nblk",  128'(q.size()), 128'd2);
    chk("t4_blk0",  qget(0), 128'h000102030405060708090A0B0C0D0E0F);
    chk("t4_blk1",  qget(1), 128'h101112131415161718191A1B1C1D1E1F);
    chk("t4_last1", 128'(qlget(1)), 128'd0);
    chk("t4_cnt",   128'(blk_cnt), 128'd2);

    // 5: partial block discarded by an asynchronous mid-cycle reset.
    do_reset();
    for (int i = 0; i < 7; i++) send(8'h50 + 8'(i), 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_async_in_ready", 128'(in_ready), 128'd0);
    chk("t5_async_cnt", 128'(blk_cnt), 128'd0);
    #2;
    rst_n = 1'b1;
    q.delete(); ql.delete(); q0.delete(); ql0.delete();
    @(negedge clk);
    for (int i = 0; i < 16; i++) send(8'h20 + 8'(i), 1'b0);
    idle(4);
    chk("t5_nblk", 128'(q.size()), 128'd1);
    chk("t5_blk0", qget(0), 128'h202122232425262728292A2B2C2D2E2F);
    chk("t5_cnt",  128'(blk_cnt), 128'd1);

    // 6: single-byte message, then a fresh message from lane 0.
    do_reset();
    send(8'h41, 1'b1);
    chk("t6_data", blk_data, {8'h41, {15{8'h0F}}});
    chk("t6_last", 128'(blk_last), 128'd1);
    send(8'h61, 1'b0);
    send(8'h62, 1'b0);
    send(8'h63, 1'b1);
    idle(4);
    chk("t6_nblk", 128'(q.size()), 128'd2);
    chk("t6_blk1", qget(1), {8'h61, 8'h62, 8'h63, {13{8'h0D}}});
    chk("t6_last1", 128'(qlget(1)), 128'd1);
    chk("t6_cnt", 128'(blk_cnt), 128'd2);

    // 7: four full blocks; the 2-bit counter wraps back to zero.
    do_reset();
    for (int i = 0; i < 64; i++) send(8'(i), 1'b0);
    idle(4);
    chk("t7_cnt",       128'(blk_cnt),  128'd4);
    chk("t7_cnt_wrap",  128'(blk_cnt0), 128'd0);
    chk("t7_blk3",      qget(3), 128'h303132333435363738393A3B3C3D3E3F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
